peak_scan_controller: RTL and testbench

Sequences one peak search per FFT frame. On a frame-ready pulse from the FFT magnitude buffer it reads bins MIN_BIN..MAX_BIN from the magnitude BRAM, streams them into serial_peak_finder with an aligned start pulse and bin index, waits out the pipeline, then latches the winning bin and pulses peak_valid toward the pitch/note logic. It also queues one pending frame and counts frames it had to drop.

---
 rtl/peak_scan_controller.sv | 186 ++++++++++++++++++
 tb/tb_peak_scan_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_scan_controller.sv
// -----------------------------------------------------------------------------
// peak_scan_controller
//
// Runs one peak search per FFT frame. A frame_ready pulse starts a scan:
// bins MIN_BIN..MAX_BIN are read from the magnitude BRAM one per cycle. Each
// sample is streamed to serial_peak_finder together with its bin index and a
// start marker on the first bin. The controller then waits out the BRAM and
// peak-finder pipelines, latches the winning bin and pulses peak_valid.
// One frame that arrives while busy is remembered as pending. Any further
// frames that arrive while one is already pending are counted as dropped.
//
// Parameters
//   ADDR_W      bin address / index width
//   DATA_W      magnitude width
//   MIN_BIN     first bin scanned (skips DC)
//   MAX_BIN     last bin scanned
//   RD_LATENCY  cycles from mag_addr to valid mag_data (>= 1)
//   PF_LATENCY  cycles from last peak-finder sample to a final pf_peak_index
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high; clears all state
//   enable          allows new scans to start
//   frame_ready     one-cycle pulse: a new magnitude frame is in the BRAM
//   mag_addr        BRAM read address
//   mag_data        BRAM read data, RD_LATENCY cycles after mag_addr
//   pf_start        peak finder: first sample of the frame
//   pf_index        peak finder: bin index of pf_data
//   pf_data         peak finder: magnitude sample (0 when no sample is valid)
//   pf_peak_index   peak finder: current winning bin
//   peak_bin        winning bin of the last completed scan
//   peak_valid      one-cycle pulse when peak_bin updates
//   busy            high while in SCAN, DRAIN or CAPTURE
//   frames_dropped  saturating count of discarded frames
// -----------------------------------------------------------------------------
module peak_scan_controller #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MIN_BIN    = 2,
    parameter int MAX_BIN    = 511,
    parameter int RD_LATENCY = 2,
    parameter int PF_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_ready,
    output logic [ADDR_W-1:0] mag_addr,
    input  logic [DATA_W-1:0] mag_data,
    output logic              pf_start,
    output logic [ADDR_W-1:0] pf_index,
    output logic [DATA_W-1:0] pf_data,
    input  logic [11:0]       pf_peak_index,
    output logic [11:0]       peak_bin,
    output logic              peak_valid,
    output logic              busy,
    output logic [7:0]        frames_dropped
);

    localparam int DRAIN_CYCLES = RD_LATENCY + PF_LATENCY;
    localparam int CNT_W        = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0] MIN_ADDR   = ADDR_W'(MIN_BIN);
    localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(MAX_BIN);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        CAPTURE
    } state_t;

    state_t             state;
    logic               pending;
    logic [CNT_W-1:0]   drain_cnt;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [ADDR_W-1:0]     addr_pipe [RD_LATENCY];
    logic [ADDR_W-1:0]     last_index;

    logic               start_scan;
    logic               drop;
    logic               sample_vld;
    logic [ADDR_W-1:0]  sample_addr;

    // A frame is queued when one arrives and no scan can take it right now.
    // A frame that finds another already queued is lost, even when the
    // queued one is being consumed in the same cycle.
    assign start_scan = (state == IDLE) && enable && (frame_ready || pending);
    assign drop       = frame_ready && pending;

    assign busy = (state != IDLE);

    // Scan sequencer: address generation, drain timer and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mag_addr   <= '0;
            drain_cnt  <= '0;
            peak_bin   <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_scan) begin
                        mag_addr <= MIN_ADDR;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    // mag_addr stays on MAX_BIN after the last read; it never wraps.
                    if (mag_addr == MAX_ADDR) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        mag_addr <= mag_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    peak_bin   <= pf_peak_index;
                    peak_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending-frame flag and the saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending        <= 1'b0;
            frames_dropped <= '0;
        end else begin
            if (start_scan) begin
                pending <= 1'b0;
            end else if (frame_ready) begin
                pending <= 1'b1;
            end
            if (drop && (frames_dropped != 8'hFF)) begin
                frames_dropped <= frames_dropped + 8'd1;
            end
        end
    end

    // Valid and address travel together through a pipeline as deep as the
    // BRAM read latency, so the tail lines up with mag_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe   <= '0;
            last_index <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= (state == SCAN);
            addr_pipe[0] <= mag_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            if (sample_vld) begin
                last_index <= sample_addr;
            end
        end
    end

    assign sample_vld  = vld_pipe[RD_LATENCY-1];
    assign sample_addr = addr_pipe[RD_LATENCY-1];

    // Between samples pf_index holds the last bin so the peak finder never
    // sees a spurious index change; pf_data is forced to zero.
    assign pf_data  = sample_vld ? mag_data : '0;
    assign pf_index = sample_vld ? sample_addr : last_index;
    assign pf_start = sample_vld && (sample_addr == MIN_ADDR);

endmodule

// File: tb/tb_peak_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_peak_scan_controller
//
// Directed bench for peak_scan_controller. The main instance uses the default
// build, with a 2-cycle BRAM model and a 3-cycle running-max peak-finder
// model. A second instance is built with MIN_BIN=0 and MAX_BIN=3. It is fed
// all-zero magnitudes and a fixed peak index.
// -----------------------------------------------------------------------------
module tb_peak_scan_controller;

    localparam int N_BINS = 510;
    localparam int PV_T   = 516;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_ready;
    logic [8:0]  mag_addr;
    logic [31:0] mag_data;
    logic        pf_start;
    logic [8:0]  pf_index;
    logic [31:0] pf_data;
    logic [11:0] pf_peak_index;
    logic [11:0] peak_bin;
    logic        peak_valid;
    logic        busy;
    logic [7:0]  frames_dropped;

    logic        s_enable;
    logic        s_frame_ready;
    logic [8:0]  s_mag_addr;
    logic        s_pf_start;
    logic [8:0]  s_pf_index;
    logic [31:0] s_pf_data;
    logic [11:0] s_peak_bin;
    logic        s_peak_valid;
    logic        s_busy;
    logic [7:0]  s_frames_dropped;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    peak_scan_controller dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_ready(frame_ready),
        .mag_addr(mag_addr), .mag_data(mag_data), .pf_start(pf_start),
        .pf_index(pf_index), .pf_data(pf_data), .pf_peak_index(pf_peak_index),
        .peak_bin(peak_bin), .peak_valid(peak_valid), .busy(busy),
        .frames_dropped(frames_dropped)
    );

    peak_scan_controller #(.MIN_BIN(0), .MAX_BIN(3)) dut_small (
        .clk(clk), .reset(reset), .enable(s_enable), .frame_ready(s_frame_ready),
        .mag_addr(s_mag_addr), .mag_data(32'd0), .pf_start(s_pf_start),
        .pf_index(s_pf_index), .pf_data(s_pf_data), .pf_peak_index(12'hABC),
        .peak_bin(s_peak_bin), .peak_valid(s_peak_valid), .busy(s_busy),
        .frames_dropped(s_frames_dropped)
    );

    // Magnitude frame: 14*bin up to bin 300, then falling 28 per bin, floored at 0.
    function automatic logic [31:0] mag_of(input int bin);
        int v;
        if (bin <= 300) v = 14 * bin;
        else            v = 4200 - 28 * (bin - 300);
        if (v < 0) v = 0;
        return 32'(v);
    endfunction

    // BRAM model with a two-cycle read latency.
    logic [31:0] rd_stage = '0;
    always @(posedge clk) begin
        rd_stage <= mag_of(int'(mag_addr));
        mag_data <= rd_stage;
    end

    // Running-max peak finder; the result settles 3 cycles after the last sample.
    logic [31:0] best     = '0;
    logic [11:0] best_idx = '0;
    logic [11:0] pk_d1    = '0;
    logic [11:0] pk_d2    = '0;
    always @(posedge clk) begin
        if (pf_start) begin
            best     <= pf_data;
            best_idx <= 12'(pf_index);
        end else if (pf_data > best) begin
            best     <= pf_data;
            best_idx <= 12'(pf_index);
        end
        pk_d1 <= best_idx;
        pk_d2 <= pk_d1;
    end
    assign pf_peak_index = pk_d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        frame_ready = 1'b0;
        s_enable = 1'b0;
        s_frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    // Pulses frame_ready on the main instance; returns in the first SCAN cycle (T0).
    task automatic pulse_frame();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        frame_ready = 1'b0;
        s_enable = 1'b0;
        s_frame_ready = 1'b0;
        #3;
        tests_run++; if (mag_addr !== 9'd0) begin tests_failed++; $display("[TB] FAIL reset_mag_addr: got %0d expected 0", mag_addr); end
        tests_run++; if ({pf_start, pf_index, pf_data} !== '0) begin tests_failed++; $display("[TB] FAIL reset_pf: start %b index %0d data %0d expected all 0", pf_start, pf_index, pf_data); end
        tests_run++; if ({peak_bin, peak_valid, busy} !== '0) begin tests_failed++; $display("[TB] FAIL reset_result: bin %0d valid %b busy %b expected all 0", peak_bin, peak_valid, busy); end
        tests_run++; if (frames_dropped !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_dropped: got %0d expected 0", frames_dropped); end
        do_reset();
    endtask

    task automatic test_basic_scan();
        int starts = 0, start_idx = -1, start_t = -1, pv_count = 0, pv_t = -1;
        do_reset();
        enable = 1'b1;
        pulse_frame();
        for (int t = 0; t < 530; t++) begin
            if (t == 0) begin
                tests_run++; if (mag_addr !== 9'd2 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_t0: addr %0d busy %b expected 2 1", mag_addr, busy); end
            end
            if (t == N_BINS - 1) begin
                tests_run++; if (mag_addr !== 9'd511) begin tests_failed++; $display("[TB] FAIL basic_last_addr: got %0d expected 511", mag_addr); end
            end
            if (t == 300) begin
                tests_run++; if (pf_index !== 9'd300 || pf_data !== 32'd4200) begin tests_failed++; $display("[TB] FAIL basic_bin300: index %0d data %0d expected 300 4200", pf_index, pf_data); end
            end
            if (t == PV_T - 1) begin
                tests_run++; if (busy !== 1'b1 || peak_bin !== 12'd0) begin tests_failed++; $display("[TB] FAIL basic_capture: busy %b bin %0d expected 1 0", busy, peak_bin); end
            end
            if (t == PV_T) begin
                tests_run++; if (busy !== 1'b0 || peak_bin !== 12'd300) begin tests_failed++; $display("[TB] FAIL basic_result: busy %b bin %0d expected 0 300", busy, peak_bin); end
            end
            if (pf_start === 1'b1) begin starts++; start_idx = int'(pf_index); start_t = t; end
            if (peak_valid === 1'b1) begin pv_count++; pv_t = t; end
            tick();
        end
        tests_run++; if (starts != 1 || start_idx != 2 || start_t != 2) begin tests_failed++; $display("[TB] FAIL basic_pf_start: count %0d index %0d at %0d expected 1 2 2", starts, start_idx, start_t); end
        tests_run++; if (pv_count != 1 || pv_t != PV_T) begin tests_failed++; $display("[TB] FAIL basic_peak_valid: count %0d at %0d expected 1 at %0d", pv_count, pv_t, PV_T); end
    endtask

    task automatic test_back_to_back();
        int pv_count = 0, pv1 = -1, pv2 = -1;
        do_reset();
        enable = 1'b1;
        pulse_frame();
        for (int t = 0; t < 1045; t++) begin
            frame_ready = (t == 100);
            if (t == PV_T) begin
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle_gap: busy %b expected 0", busy); end
            end
            if (t == PV_T + 1) begin
                tests_run++; if (busy !== 1'b1 || mag_addr !== 9'd2) begin tests_failed++; $display("[TB] FAIL b2b_second_t0: busy %b addr %0d expected 1 2", busy, mag_addr); end
            end
            if (peak_valid === 1'b1) begin
                pv_count++;
                if (pv_count == 1) pv1 = t; else pv2 = t;
            end
            tick();
        end
        frame_ready = 1'b0;
        tests_run++; if (pv_count != 2 || pv1 != PV_T || pv2 != 2 * PV_T + 1) begin tests_failed++; $display("[TB] FAIL b2b_peak_valid: count %0d at %0d,%0d expected 2 at %0d,%0d", pv_count, pv1, pv2, PV_T, 2 * PV_T + 1); end
        tests_run++; if (frames_dropped !== 8'd0 || peak_bin !== 12'd300) begin tests_failed++; $display("[TB] FAIL b2b_state: dropped %0d bin %0d expected 0 300", frames_dropped, peak_bin); end
    endtask

    task automatic test_drops();
        int pv_count = 0, busy_seen = 0;
        do_reset();
        enable = 1'b1;
        pulse_frame();
        for (int t = 0; t < 1045; t++) begin
            frame_ready = (t == 50 || t == 60 || t == 70);
            if (t == 80) begin
                tests_run++; if (frames_dropped !== 8'd2) begin tests_failed++; $display("[TB] FAIL drop_three: got %0d expected 2", frames_dropped); end
            end
            if (peak_valid === 1'b1) pv_count++;
            tick();
        end
        frame_ready = 1'b0;
        tests_run++; if (pv_count != 2) begin tests_failed++; $display("[TB] FAIL drop_pending_scan: %0d peak_valid pulses expected 2", pv_count); end
        // With enable low the first pulse is queued and every later one drops.
        enable = 1'b0;
        for (int i = 0; i < 253; i++) begin
            frame_ready = 1'b1; tick();
            frame_ready = 1'b0;
            if (busy === 1'b1) busy_seen++;
            tick();
        end
        tests_run++; if (frames_dropped !== 8'd254) begin tests_failed++; $display("[TB] FAIL drop_count_254: got %0d expected 254", frames_dropped); end
        for (int i = 0; i < 47; i++) begin
            frame_ready = 1'b1; tick();
            frame_ready = 1'b0;
            if (busy === 1'b1) busy_seen++;
            tick();
        end
        tests_run++; if (frames_dropped !== 8'd255) begin tests_failed++; $display("[TB] FAIL drop_saturate: got %0d expected 255", frames_dropped); end
        tests_run++; if (busy_seen != 0) begin tests_failed++; $display("[TB] FAIL drop_disabled_busy: busy seen %0d cycles expected 0", busy_seen); end
    endtask

    task automatic test_enable();
        int busy_seen = 0, pv_count = 0, pv_t = -1;
        do_reset();
        enable = 1'b0;
        pulse_frame();
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_seen++;
            tick();
        end
        tests_run++; if (busy_seen != 0) begin tests_failed++; $display("[TB] FAIL enable_low_busy: busy seen %0d cycles expected 0", busy_seen); end
        enable = 1'b1;
        tick();
        tests_run++; if (busy !== 1'b1 || mag_addr !== 9'd2) begin tests_failed++; $display("[TB] FAIL enable_rise_start: busy %b addr %0d expected 1 2", busy, mag_addr); end
        for (int t = 0; t < 525; t++) begin
            if (t == 50) enable = 1'b0;
            if (peak_valid === 1'b1) begin pv_count++; pv_t = t; end
            tick();
        end
        tests_run++; if (pv_count != 1 || pv_t != PV_T || peak_bin !== 12'd300) begin tests_failed++; $display("[TB] FAIL enable_drop_midscan: count %0d at %0d bin %0d expected 1 at %0d bin 300", pv_count, pv_t, peak_bin, PV_T); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL enable_after_scan_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_midscan();
        int pv_count = 0, pv_t = -1;
        do_reset();
        enable = 1'b1;
        pulse_frame();
        for (int t = 0; t < 200; t++) tick();
        reset = 1'b1;
        #1;
        tests_run++; if (mag_addr !== 9'd0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_seq: addr %0d busy %b expected 0 0", mag_addr, busy); end
        tests_run++; if ({pf_start, pf_index, pf_data} !== '0) begin tests_failed++; $display("[TB] FAIL midreset_pf: start %b index %0d data %0d expected all 0", pf_start, pf_index, pf_data); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (peak_valid === 1'b1) pv_count++;
            tick();
        end
        tests_run++; if (pv_count != 0 || peak_bin !== 12'd0) begin tests_failed++; $display("[TB] FAIL midreset_no_result: pulses %0d bin %0d expected 0 0", pv_count, peak_bin); end
        pulse_frame();
        for (int t = 0; t < 520; t++) begin
            if (peak_valid === 1'b1) begin pv_count++; pv_t = t; end
            tick();
        end
        tests_run++; if (pv_count != 1 || pv_t != PV_T || peak_bin !== 12'd300) begin tests_failed++; $display("[TB] FAIL midreset_rescan: count %0d at %0d bin %0d expected 1 at %0d bin 300", pv_count, pv_t, peak_bin, PV_T); end
    endtask

    task automatic test_small_build();
        int data_nz = 0, starts = 0, start_t = -1, idx_err = 0, pv_count = 0, pv_t = -1;
        do_reset();
        s_enable = 1'b1;
        s_frame_ready = 1'b1;
        tick();
        s_frame_ready = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (s_pf_data !== 32'd0) data_nz++;
            if (s_pf_start === 1'b1) begin starts++; start_t = t; end
            if (t >= 2 && t <= 5 && s_pf_index !== 9'(t - 2)) idx_err++;
            if (t >= 6 && t <= 12 && s_pf_index !== 9'd3) idx_err++;
            if (t == 3) begin
                tests_run++; if (s_mag_addr !== 9'd3 || s_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL small_addr: addr %0d busy %b expected 3 1", s_mag_addr, s_busy); end
            end
            if (t == 9) begin
                tests_run++; if (s_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL small_capture_busy: got %b expected 1", s_busy); end
            end
            if (s_peak_valid === 1'b1) begin pv_count++; pv_t = t; end
            tick();
        end
        tests_run++; if (data_nz != 0) begin tests_failed++; $display("[TB] FAIL small_pf_data: nonzero in %0d cycles expected 0", data_nz); end
        tests_run++; if (starts != 1 || start_t != 2) begin tests_failed++; $display("[TB] FAIL small_pf_start: count %0d at %0d expected 1 at 2", starts, start_t); end
        tests_run++; if (idx_err != 0) begin tests_failed++; $display("[TB] FAIL small_pf_index: %0d wrong cycles expected 0", idx_err); end
        tests_run++; if (pv_count != 1 || pv_t != 10 || s_peak_bin !== 12'hABC) begin tests_failed++; $display("[TB] FAIL small_result: count %0d at %0d bin %0h expected 1 at 10 bin abc", pv_count, pv_t, s_peak_bin); end
        tests_run++; if (s_busy !== 1'b0 || s_frames_dropped !== 8'd0) begin tests_failed++; $display("[TB] FAIL small_end_state: busy %b dropped %0d expected 0 0", s_busy, s_frames_dropped); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_back_to_back();
        test_drops();
        test_enable();
        test_reset_midscan();
        test_small_build();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
